// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS hazard / forwarding controller.
package mips_pkg;

    localparam int REG_AW = 5;

    // Operand source selected for an EX-stage ALU input.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Controller state: normal flow, waiting on data memory, or latched memory fault.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_e;

    // A register read depends on a writer when the writer is enabled,
    // its destination is not $zero and the register numbers agree.
    function automatic logic reg_match(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] d,
        input logic              we
    );
        return we && (d != '0) && (d == r);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select: MEM-stage result beats WB-stage result beats register file.
module fwd_unit
    import mips_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_m_dest,
    input  logic              i_m_reg_write,
    input  logic [REG_AW-1:0] i_wb_dest,
    input  logic              i_wb_reg_write,
    output fwd_sel_e          o_fwd_a_sel,
    output fwd_sel_e          o_fwd_b_sel
);

    function automatic fwd_sel_e pick(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] m_d,
        input logic              m_we,
        input logic [REG_AW-1:0] wb_d,
        input logic              wb_we
    );
        if (reg_match(r, m_d, m_we))
            return FWD_MEM;
        if (reg_match(r, wb_d, wb_we))
            return FWD_WB;
        return FWD_RF;
    endfunction

    // Select a source for each ALU operand; stall-only builds always read the register file.
    always_comb begin
        o_fwd_a_sel = FWD_RF;
        o_fwd_b_sel = FWD_RF;
        if (FWD_EN != 0) begin
            o_fwd_a_sel = pick(i_ex_rs, i_m_dest, i_m_reg_write, i_wb_dest, i_wb_reg_write);
            o_fwd_b_sel = pick(i_ex_rt, i_m_dest, i_m_reg_write, i_wb_dest, i_wb_reg_write);
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch redirect flushes,
// data-memory wait handling with timeout, forwarding selects and event counters.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] m_dest,
    input  logic              m_reg_write,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_reg_write,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              exmem_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  mem_wait_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    hz_state_e         r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_mem_wait_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic     w_id_hit_ex;
    logic     w_id_hit_m;
    logic     w_hz_stall;
    logic     w_mem_stall;
    logic     w_in_err;
    logic     w_stall_take;
    logic     w_mem_take;
    logic     w_flush_take;
    fwd_sel_e w_fwd_a_sel;
    fwd_sel_e w_fwd_b_sel;

    fwd_unit #(
        .FWD_EN (FWD_EN)
    ) u_fwd_unit (
        .i_ex_rs        (ex_rs),
        .i_ex_rt        (ex_rt),
        .i_m_dest       (m_dest),
        .i_m_reg_write  (m_reg_write),
        .i_wb_dest      (wb_dest),
        .i_wb_reg_write (wb_reg_write),
        .o_fwd_a_sel    (w_fwd_a_sel),
        .o_fwd_b_sel    (w_fwd_b_sel)
    );

    assign fwd_a_sel = w_fwd_a_sel;
    assign fwd_b_sel = w_fwd_b_sel;

    // A used ID operand depends on the instruction now in EX or in MEM.
    assign w_id_hit_ex = (id_uses_rs && reg_match(id_rs, ex_dest, ex_reg_write)) ||
                         (id_uses_rt && reg_match(id_rt, ex_dest, ex_reg_write));
    assign w_id_hit_m  = (id_uses_rs && reg_match(id_rs, m_dest, m_reg_write)) ||
                         (id_uses_rt && reg_match(id_rt, m_dest, m_reg_write));

    // With forwarding only a load result is too late; without it any in-flight writer
    // ahead of WB blocks the read (WB itself writes the register file before ID reads it).
    assign w_hz_stall  = (FWD_EN != 0) ? (ex_mem_read && w_id_hit_ex)
                                       : (w_id_hit_ex || w_id_hit_m);

    assign w_mem_stall = !mem_ready && ((r_state == RUN && mem_req) || r_state == MEM_WAIT);
    assign w_in_err    = (r_state == ERR);

    // Which event actually owns the pipeline this cycle, after priority resolution.
    assign w_mem_take   = !w_in_err && w_mem_stall;
    assign w_flush_take = !w_in_err && !w_mem_stall && ex_redirect;
    assign w_stall_take = !w_in_err && !w_mem_stall && !ex_redirect && w_hz_stall;

    // Pipeline register enables, flushes and bubble, resolved by priority.
    always_comb begin
        // NOTE: every output gets its default first so no path through the ifs infers a latch.
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (w_in_err) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (w_mem_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_hz_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Memory-wait FSM with timeout counter; ERR is sticky until reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == WAIT_MAX) begin
                        r_state   <= ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end
                ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Saturating event counters; clear beats increment.
    always_ff @(posedge clk) begin
        // NOTE: counters are real state and must be reset; they are flops, not a memory array.
        if (!rst_n || cnt_clr) begin
            r_stall_cnt    <= '0;
            r_mem_wait_cnt <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (w_stall_take && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_mem_take && r_mem_wait_cnt != CNT_MAX)
                r_mem_wait_cnt <= r_mem_wait_cnt + CNT_ONE;
            if (w_flush_take && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign mem_err      = r_mem_err;
    assign stall_cnt    = r_stall_cnt;
    assign mem_wait_cnt = r_mem_wait_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Bench for mips_hazard_ctrl: one forwarding build (timeout 4) and one stall-only
// build (4-bit counters) share the same stimulus; directed scenarios plus a random run.
module tb_mips_hazard_ctrl;

    localparam logic [7:0] CTL_ERR   = 8'b0000_0001;
    localparam logic [7:0] CTL_MEM   = 8'b0000_0010;
    localparam logic [7:0] CTL_REDIR = 8'b1111_1100;
    localparam logic [7:0] CTL_HZ    = 8'b0011_0100;
    localparam logic [7:0] CTL_NORM  = 8'b1111_0000;
    localparam logic [7:0] CTL_TBL [5] = '{CTL_ERR, CTL_MEM, CTL_REDIR, CTL_HZ, CTL_NORM};

    logic       clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, m_dest, wb_dest;
    logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, ex_redirect;
    logic       m_reg_write, wb_reg_write, mem_req, mem_ready, cnt_clr;

    logic        pc_write0, ifid_write0, idex_write0, exmem_write0, ifid_flush0, idex_flush0, memwb_bubble0, mem_err0;
    logic [1:0]  fwd_a0, fwd_b0;
    logic [31:0] stall_cnt0, mem_wait_cnt0, flush_cnt0;
    logic        pc_write1, ifid_write1, idex_write1, exmem_write1, ifid_flush1, idex_flush1, memwb_bubble1, mem_err1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [3:0]  stall_cnt1, mem_wait_cnt1, flush_cnt1;

    logic [7:0]  ctl_act   [2];
    logic [3:0]  fwd_act   [2];
    logic [31:0] stall_act [2];
    logic [31:0] memw_act  [2];
    logic [31:0] flush_act [2];

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = forwarding build, 1 = stall-only build.
    int     m_fwd_en [2] = '{1, 0};
    int     m_tmo    [2] = '{4, 255};
    longint m_cmax   [2] = '{64'hFFFF_FFFF, 64'd15};
    int     m_mode   [2];   // 0 running, 1 waiting on memory, 2 faulted
    int     m_waited [2];
    longint m_stall  [2];
    longint m_memw   [2];
    longint m_flush  [2];

    mips_hazard_ctrl #(.FWD_EN(1), .CNT_W(32), .MEM_TIMEOUT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .m_dest(m_dest), .m_reg_write(m_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_write(pc_write0), .ifid_write(ifid_write0), .idex_write(idex_write0), .exmem_write(exmem_write0),
        .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .memwb_bubble(memwb_bubble0),
        .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0), .mem_err(mem_err0),
        .stall_cnt(stall_cnt0), .mem_wait_cnt(mem_wait_cnt0), .flush_cnt(flush_cnt0)
    );

    mips_hazard_ctrl #(.FWD_EN(0), .CNT_W(4), .MEM_TIMEOUT(255)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .m_dest(m_dest), .m_reg_write(m_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_write(pc_write1), .ifid_write(ifid_write1), .idex_write(idex_write1), .exmem_write(exmem_write1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .memwb_bubble(memwb_bubble1),
        .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1), .mem_err(mem_err1),
        .stall_cnt(stall_cnt1), .mem_wait_cnt(mem_wait_cnt1), .flush_cnt(flush_cnt1)
    );

    assign ctl_act[0]   = {pc_write0, ifid_write0, idex_write0, exmem_write0, ifid_flush0, idex_flush0, memwb_bubble0, mem_err0};
    assign ctl_act[1]   = {pc_write1, ifid_write1, idex_write1, exmem_write1, ifid_flush1, idex_flush1, memwb_bubble1, mem_err1};
    assign fwd_act[0]   = {fwd_a0, fwd_b0};
    assign fwd_act[1]   = {fwd_a1, fwd_b1};
    assign stall_act[0] = stall_cnt0;
    assign stall_act[1] = {28'd0, stall_cnt1};
    assign memw_act[0]  = mem_wait_cnt0;
    assign memw_act[1]  = {28'd0, mem_wait_cnt1};
    assign flush_act[0] = flush_cnt0;
    assign flush_act[1] = {28'd0, flush_cnt1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0;
        m_dest = 0; m_reg_write = 0; wb_dest = 0; wb_reg_write = 0;
        mem_req = 0; mem_ready = 1; cnt_clr = 0;
    endtask

    // Inputs change one unit after the falling edge, outputs are read one unit later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        next_cycle();
        next_cycle();
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++; if (ctl_act[k] !== CTL_NORM) begin fails++; $display("FAIL reset_ctl%0d: got %b want %b", k, ctl_act[k], CTL_NORM); end
            tests++; if ({stall_act[k], memw_act[k], flush_act[k]} !== 96'd0) begin fails++; $display("FAIL reset_cnt%0d: got %0d/%0d/%0d want 0/0/0", k, stall_act[k], memw_act[k], flush_act[k]); end
        end
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        tests++; if (ctl_act[0] !== CTL_HZ) begin fails++; $display("FAIL load_use_ctl0: got %b want %b", ctl_act[0], CTL_HZ); end
        tests++; if (stall_act[0] !== 32'd0) begin fails++; $display("FAIL load_use_cnt_before: got %0d want 0", stall_act[0]); end
        next_cycle();
        idle();
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL load_use_release: got %b want %b", ctl_act[0], CTL_NORM); end
        tests++; if (stall_act[0] !== 32'd1) begin fails++; $display("FAIL load_use_cnt_after0: got %0d want 1", stall_act[0]); end
        tests++; if (stall_act[1] !== 32'd1) begin fails++; $display("FAIL load_use_cnt_after1: got %0d want 1", stall_act[1]); end
        next_cycle();
        // Matching operand that the instruction does not read.
        set_load_use(); id_uses_rs = 0;
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL unused_operand: got %b want %b", ctl_act[0], CTL_NORM); end
        next_cycle();
        // Register $zero never creates a dependency.
        idle(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_NORM, CTL_NORM}) begin fails++; $display("FAIL zero_reg: got %b/%b want %b/%b", ctl_act[0], ctl_act[1], CTL_NORM, CTL_NORM); end
        next_cycle();
        // Non-load EX writer: forwarding build proceeds, stall-only build waits.
        idle(); ex_reg_write = 1; ex_dest = 5; id_rt = 5; id_uses_rt = 1;
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL alu_dep_fwd: got %b want %b", ctl_act[0], CTL_NORM); end
        tests++; if (ctl_act[1] !== CTL_HZ) begin fails++; $display("FAIL alu_dep_nofwd: got %b want %b", ctl_act[1], CTL_HZ); end
        idle();
        next_cycle();
    endtask

    task automatic test_forward();
        do_reset();
        ex_rs = 7; ex_rt = 7; m_dest = 7; wb_dest = 7; m_reg_write = 1; wb_reg_write = 1;
        #1;
        tests++; if (fwd_act[0] !== 4'b1010) begin fails++; $display("FAIL fwd_mem_first: got %b want %b", fwd_act[0], 4'b1010); end
        tests++; if (fwd_act[1] !== 4'b0000) begin fails++; $display("FAIL fwd_disabled: got %b want %b", fwd_act[1], 4'b0000); end
        next_cycle();
        m_reg_write = 0;
        #1;
        tests++; if (fwd_act[0] !== 4'b0101) begin fails++; $display("FAIL fwd_wb: got %b want %b", fwd_act[0], 4'b0101); end
        next_cycle();
        m_reg_write = 1; m_dest = 0; wb_dest = 0; ex_rs = 0; ex_rt = 0;
        #1;
        tests++; if (fwd_act[0] !== 4'b0000) begin fails++; $display("FAIL fwd_zero_dest: got %b want %b", fwd_act[0], 4'b0000); end
        next_cycle();
        m_dest = 7; ex_rs = 7; wb_dest = 9; ex_rt = 9;
        #1;
        tests++; if (fwd_act[0] !== 4'b1001) begin fails++; $display("FAIL fwd_split: got %b want %b", fwd_act[0], 4'b1001); end
        idle();
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_MEM, CTL_MEM}) begin fails++; $display("FAIL mem_wait_c%0d: got %b/%b want %b", i, ctl_act[0], ctl_act[1], CTL_MEM); end
            next_cycle();
        end
        mem_req = 0; mem_ready = 1;
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL mem_ready_release: got %b want %b", ctl_act[0], CTL_NORM); end
        next_cycle();
        mem_ready = 0;
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL mem_back_to_run: got %b want %b", ctl_act[0], CTL_NORM); end
        tests++; if ({memw_act[0], memw_act[1]} !== {32'd3, 32'd3}) begin fails++; $display("FAIL mem_wait_cnt: got %0d/%0d want 3/3", memw_act[0], memw_act[1]); end
        idle();
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (ctl_act[0] !== CTL_MEM) begin fails++; $display("FAIL timeout_wait_c%0d: got %b want %b", i, ctl_act[0], CTL_MEM); end
            next_cycle();
        end
        #1;
        tests++; if (ctl_act[0] !== CTL_ERR) begin fails++; $display("FAIL timeout_err: got %b want %b", ctl_act[0], CTL_ERR); end
        tests++; if (ctl_act[1] !== CTL_MEM) begin fails++; $display("FAIL timeout_long_wait: got %b want %b", ctl_act[1], CTL_MEM); end
        mem_req = 0; mem_ready = 1; ex_redirect = 1;
        #1;
        tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_ERR, CTL_REDIR}) begin fails++; $display("FAIL err_over_redirect: got %b/%b want %b/%b", ctl_act[0], ctl_act[1], CTL_ERR, CTL_REDIR); end
        next_cycle();
        next_cycle();
        tests++; if (ctl_act[0] !== CTL_ERR) begin fails++; $display("FAIL err_sticky: got %b want %b", ctl_act[0], CTL_ERR); end
        tests++; if ({memw_act[0], flush_act[0]} !== {32'd6, 32'd0}) begin fails++; $display("FAIL err_counts: got %0d/%0d want 6/0", memw_act[0], flush_act[0]); end
        tests++; if (flush_act[1] !== 32'd2) begin fails++; $display("FAIL redirect_count1: got %0d want 2", flush_act[1]); end
        ex_redirect = 0; rst_n = 0;
        next_cycle();
        rst_n = 1;
        #1;
        tests++; if (ctl_act[0] !== CTL_NORM) begin fails++; $display("FAIL err_reset_exit: got %b want %b", ctl_act[0], CTL_NORM); end
        // Reset taken in the middle of a memory wait.
        mem_req = 1; mem_ready = 0;
        next_cycle();
        #1;
        tests++; if (ctl_act[1] !== CTL_MEM) begin fails++; $display("FAIL midwait_pre: got %b want %b", ctl_act[1], CTL_MEM); end
        rst_n = 0; mem_req = 0;
        next_cycle();
        rst_n = 1;
        #1;
        tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_NORM, CTL_NORM}) begin fails++; $display("FAIL midwait_reset: got %b/%b want %b", ctl_act[0], ctl_act[1], CTL_NORM); end
        idle();
        next_cycle();
    endtask

    task automatic test_redirect_hazard();
        do_reset();
        set_load_use();
        ex_redirect = 1;
        #1;
        tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_REDIR, CTL_REDIR}) begin fails++; $display("FAIL redirect_ctl: got %b/%b want %b", ctl_act[0], ctl_act[1], CTL_REDIR); end
        next_cycle();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++; if ({flush_act[k], stall_act[k]} !== {32'd1, 32'd0}) begin fails++; $display("FAIL redirect_cnt%0d: got flush %0d stall %0d want 1/0", k, flush_act[k], stall_act[k]); end
        end
        next_cycle();
    endtask

    task automatic test_stall_only_sat();
        do_reset();
        m_dest = 3; m_reg_write = 1; id_rt = 3; id_uses_rt = 1;
        #1;
        tests++; if ({ctl_act[0], ctl_act[1]} !== {CTL_NORM, CTL_HZ}) begin fails++; $display("FAIL mem_dep: got %b/%b want %b/%b", ctl_act[0], ctl_act[1], CTL_NORM, CTL_HZ); end
        repeat (20) next_cycle();
        #1;
        tests++; if ({stall_act[0], stall_act[1]} !== {32'd0, 32'd15}) begin fails++; $display("FAIL stall_saturate: got %0d/%0d want 0/15", stall_act[0], stall_act[1]); end
        cnt_clr = 1;
        next_cycle();
        cnt_clr = 0;
        #1;
        tests++; if (stall_act[1] !== 32'd0) begin fails++; $display("FAIL clr_priority: got %0d want 0", stall_act[1]); end
        next_cycle();
        tests++; if (stall_act[1] !== 32'd1) begin fails++; $display("FAIL count_after_clr: got %0d want 1", stall_act[1]); end
        idle();
        next_cycle();
    endtask

    // ---------- reference model for the random run ----------
    function automatic bit dep(input logic [4:0] r, input logic [4:0] d, input logic we);
        return we && (d != 5'd0) && (d == r);
    endfunction

    function automatic logic [1:0] model_src(input logic [4:0] r);
        if (dep(r, m_dest, m_reg_write))   return 2'b10;
        if (dep(r, wb_dest, wb_reg_write)) return 2'b01;
        return 2'b00;
    endfunction

    // 0 fault, 1 memory wait, 2 redirect, 3 hazard stall, 4 normal.
    function automatic int model_event(input int k);
        bit need_ex, need_m, hz, mw;
        need_ex = (id_uses_rs && dep(id_rs, ex_dest, ex_reg_write)) || (id_uses_rt && dep(id_rt, ex_dest, ex_reg_write));
        need_m  = (id_uses_rs && dep(id_rs, m_dest, m_reg_write))   || (id_uses_rt && dep(id_rt, m_dest, m_reg_write));
        hz = (m_fwd_en[k] != 0) ? (ex_mem_read && need_ex) : (need_ex || need_m);
        mw = !mem_ready && (m_mode[k] == 1 || (m_mode[k] == 0 && mem_req));
        if (m_mode[k] == 2) return 0;
        if (mw)             return 1;
        if (ex_redirect)    return 2;
        if (hz)             return 3;
        return 4;
    endfunction

    task automatic model_edge(input int k, input int ev);
        if (!rst_n) begin
            m_mode[k] = 0; m_waited[k] = 0;
            m_stall[k] = 0; m_memw[k] = 0; m_flush[k] = 0;
        end else begin
            if (cnt_clr) begin
                m_stall[k] = 0; m_memw[k] = 0; m_flush[k] = 0;
            end else begin
                if (ev == 1 && m_memw[k]  < m_cmax[k]) m_memw[k]++;
                if (ev == 2 && m_flush[k] < m_cmax[k]) m_flush[k]++;
                if (ev == 3 && m_stall[k] < m_cmax[k]) m_stall[k]++;
            end
            if (m_mode[k] == 0 && mem_req && !mem_ready) begin
                m_mode[k] = 1; m_waited[k] = 0;
            end else if (m_mode[k] == 1) begin
                if (mem_ready)                   m_mode[k] = 0;
                else if (m_waited[k] >= m_tmo[k]) m_mode[k] = 2;
                else                             m_waited[k]++;
            end
        end
    endtask

    task automatic test_random();
        int ev [2];
        logic [3:0] fwd_exp;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_waited[k] = 0; m_stall[k] = 0; m_memw[k] = 0; m_flush[k] = 0;
        end
        for (int n = 0; n < 2500; n++) begin
            id_rs = 5'($urandom_range(0, 3));  id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3));  ex_rt = 5'($urandom_range(0, 3));
            ex_dest = 5'($urandom_range(0, 3)); m_dest = 5'($urandom_range(0, 3)); wb_dest = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
            m_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 99) < 10);
            mem_req     = ($urandom_range(0, 99) < 25);
            mem_ready   = ($urandom_range(0, 99) < 60);
            cnt_clr     = ($urandom_range(0, 99) < 2);
            rst_n       = ($urandom_range(0, 99) >= 2);
            #1;
            for (int k = 0; k < 2; k++) begin
                ev[k] = model_event(k);
                fwd_exp = (m_fwd_en[k] != 0) ? {model_src(ex_rs), model_src(ex_rt)} : 4'b0000;
                tests++; if (ctl_act[k] !== CTL_TBL[ev[k]]) begin fails++; $display("FAIL rand_ctl%0d n=%0d: got %b want %b", k, n, ctl_act[k], CTL_TBL[ev[k]]); end
                tests++; if (fwd_act[k] !== fwd_exp) begin fails++; $display("FAIL rand_fwd%0d n=%0d: got %b want %b", k, n, fwd_act[k], fwd_exp); end
                tests++; if ({stall_act[k], memw_act[k], flush_act[k]} !== {32'(m_stall[k]), 32'(m_memw[k]), 32'(m_flush[k])})
                    begin fails++; $display("FAIL rand_cnt%0d n=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, n, stall_act[k], memw_act[k], flush_act[k], m_stall[k], m_memw[k], m_flush[k]); end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_edge(k, ev[k]);
            @(negedge clk);
            #1;
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(negedge clk);
        #1;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_timeout();
        test_redirect_hazard();
        test_stall_only_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_hazard_ctrl.md
MIPS_HAZARD_CTRL -- requirements
Module: mips_hazard_ctrl

Interface
REQ-001 SHALL have parameters: FWD_EN, default 1, enables EX-stage forwarding (0 = stall-only mode); CNT_W, default 32, width of each performance counter; MEM_TIMEOUT, default 255, maximum data-memory wait cycles.
REQ-002 SHALL have ports: clk in 1, the only clock; rst_n in 1, reset, synchronous and active-low.
REQ-003 SHALL have ID-operand inputs: id_rs in 5, id_rt in 5, id_uses_rs in 1, id_uses_rt in 1.
REQ-004 SHALL have EX inputs: ex_rs in 5, ex_rt in 5, ex_dest in 5, ex_reg_write in 1, ex_mem_read in 1, ex_redirect in 1.
REQ-005 SHALL have writer inputs: m_dest in 5, m_reg_write in 1, wb_dest in 5, wb_reg_write in 1.
REQ-006 SHALL have memory handshake inputs: mem_req in 1 (MEM stage accessing data memory), mem_ready in 1; and cnt_clr in 1.
REQ-007 SHALL have pipeline control outputs: pc_write, ifid_write, idex_write, exmem_write (out 1 each), plus ifid_flush, idex_flush, memwb_bubble (out 1 each).
REQ-008 SHALL have datapath outputs: fwd_a_sel out 2, fwd_b_sel out 2.
REQ-009 SHALL have status outputs: mem_err out 1; stall_cnt, mem_wait_cnt, flush_cnt out CNT_W each.

Function
REQ-010 SHALL define match(r, d, we) as true when we=1, d!=0 and d==r.
REQ-011 With FWD_EN=1, fwd_a_sel SHALL be: 2'b10 if match(ex_rs, m_dest, m_reg_write); else 2'b01 if match(ex_rs, wb_dest, wb_reg_write); else 2'b00. fwd_b_sel SHALL use the same rules on ex_rt.
REQ-012 With FWD_EN=0, fwd_a_sel and fwd_b_sel SHALL be 2'b00 at all times.
REQ-013 With FWD_EN=1, hz_stall SHALL be true when ex_mem_read=1 and an ID operand that is used matches ex_dest, evaluated with ex_reg_write.
REQ-014 With FWD_EN=0, hz_stall SHALL be true when an ID operand that is used matches ex_dest (with ex_reg_write) or m_dest (with m_reg_write).
- No WB check is needed: the register file writes before it reads.
REQ-015 mem_stall SHALL be true in RUN when mem_req=1 and mem_ready=0, and in MEM_WAIT when mem_ready=0.
REQ-016 State machine states SHALL be RUN, MEM_WAIT and ERR.
REQ-017 RUN SHALL go to MEM_WAIT when mem_req=1 and mem_ready=0, and SHALL otherwise stay in RUN.
REQ-018 MEM_WAIT SHALL go to RUN when mem_ready=1.
REQ-019 MEM_WAIT SHALL go to ERR when the wait counter reaches MEM_TIMEOUT and mem_ready=0; the wait counter SHALL be cleared on entry to MEM_WAIT.
REQ-020 ERR SHALL be left only by reset.
REQ-021 Output priority SHALL be ERR > mem_stall > ex_redirect > hz_stall > normal.
REQ-022 In ERR: all *_write outputs = 0, flushes and memwb_bubble = 0, mem_err = 1.
REQ-023 On mem_stall: pc_write = ifid_write = idex_write = exmem_write = 0, memwb_bubble = 1, flushes = 0.
REQ-024 On ex_redirect: all *_write outputs = 1, ifid_flush = idex_flush = 1; a coincident hz_stall SHALL be suppressed and SHALL NOT be counted.
REQ-025 On hz_stall: pc_write = ifid_write = 0, idex_flush = 1, idex_write = exmem_write = 1.
REQ-026 In normal operation: all *_write outputs = 1, all flushes and memwb_bubble = 0.
REQ-027 Control and forwarding outputs SHALL be combinational with zero-cycle latency; the FSM state, wait counter, mem_err and the three performance counters SHALL be registered.
REQ-028 stall_cnt SHALL add 1 per cycle in which hz_stall takes effect.
REQ-029 mem_wait_cnt SHALL add 1 per mem_stall cycle.
REQ-030 flush_cnt SHALL add 1 per cycle in which ex_redirect takes effect.
REQ-031 Each counter SHALL saturate at all-ones (no wrap).
REQ-032 cnt_clr=1 SHALL zero all three counters at the next edge, taking priority over an increment in the same cycle.

Reset
REQ-033 When rst_n=0 at a clk edge: state = RUN, wait counter = 0, mem_err = 0, all counters = 0.
REQ-034 Reset mid-MEM_WAIT or in ERR SHALL return the block to RUN with no stall on the next cycle, provided mem_req=0.

Structure
REQ-035 Package mips_pkg SHALL hold: fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), hz_state_e (RUN, MEM_WAIT, ERR) and REG_AW=5.
REQ-036 Forwarding-select logic SHALL be one combinational sub-module, fwd_unit, instantiated once.

Verification
REQ-037 ex_mem_read=1, ex_dest=5, id_rs=5, id_uses_rs=1, FWD_EN=1 -> one cycle with pc_write=0, idex_flush=1; stall_cnt goes 0->1.
REQ-038 m_dest=wb_dest=7 with both reg_write=1, ex_rs=7 -> fwd_a_sel=2'b10; the same case with dest=0 -> 2'b00.
REQ-039 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> mem_stall for 3 cycles, mem_wait_cnt=3, FSM back to RUN.
REQ-040 mem_ready held at 0 with MEM_TIMEOUT=4 -> ERR state, mem_err=1, all write enables 0 until rst_n is pulsed low.
REQ-041 ex_redirect=1 in the same cycle as a load-use hazard -> both flushes=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-042 FWD_EN=0, m_dest=3, m_reg_write=1, id_rt=3, id_uses_rt=1 -> stall asserted; CNT_W=4 with stall held 20 cycles -> stall_cnt=15.
